// File: rtl/turnstile_pkg.sv
// -----------------------------------------------------------------------------
// turnstile_pkg
//   Shared types for the turnstile bank controller:
//     lane_state_e : 3-bit lane passage state (IDLE, CHECK, ENTER, EXIT, CONFLICT, ALARM)
//     DIR_*        : per-lane direction encodings, {out,in}
//     lane_out_t   : decoded per-lane indicator bundle
//     lane_decode  : Moore decode of a lane state into its indicators
// -----------------------------------------------------------------------------
package turnstile_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHECK    = 3'd1,
    ST_ENTER    = 3'd2,
    ST_EXIT     = 3'd3,
    ST_CONFLICT = 3'd4,
    ST_ALARM    = 3'd5
  } lane_state_e;

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_IN   = 2'b01;
  localparam logic [1:0] DIR_OUT  = 2'b10;

  typedef struct packed {
    logic       green;
    logic       red;
    logic       buzzer;
    logic [1:0] dir;
  } lane_out_t;

  function automatic lane_out_t lane_decode(input lane_state_e s);
    lane_out_t o;
    o.green  = (s == ST_ENTER) || (s == ST_EXIT);
    o.red    = (s == ST_CONFLICT) || (s == ST_ALARM);
    o.buzzer = (s == ST_ALARM);
    o.dir    = (s == ST_ENTER) ? DIR_IN : ((s == ST_EXIT) ? DIR_OUT : DIR_NONE);
    return o;
  endfunction

endpackage

// File: rtl/turnstile_lane.sv
// -----------------------------------------------------------------------------
// turnstile_lane
//   Passage FSM for one turnstile lane, with an optional passage timeout
//   (enabled by defining TURNSTILE_TIMEOUT_EN).
//   Ports:
//     clk, rst    : clock, asynchronous active-high reset
//     sens_in     : entry-side presence sensor
//     sens_out    : exit-side presence sensor
//     metal       : metal detector, only looked at in CHECK
//     grant       : permission from the bank to move CHECK -> ENTER
//     alarm_ack   : guard acknowledge, clears ALARM once both sensors are clear
//     state       : registered lane state (also serves as the debug view)
//     inc, dec    : single-cycle occupancy pulses, asserted in the cycle an
//                   ENTER / EXIT passage completes (counter updates on that edge)
// -----------------------------------------------------------------------------
module turnstile_lane
  import turnstile_pkg::*;
#(
  parameter int TIMEOUT = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sens_in,
  input  logic        sens_out,
  input  logic        metal,
  input  logic        grant,
  input  logic        alarm_ack,
  output lane_state_e state,
  output logic        inc,
  output logic        dec
);

  lane_state_e state_nxt;
  logic        timeout;
  logic        clear;

  assign clear = !sens_in && !sens_out;

`ifdef TURNSTILE_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [TMR_W-1:0] tmr;

  // Timer counts cycles spent in ENTER/EXIT and restarts on every state change,
  // so an open lane stays open for exactly TIMEOUT cycles before giving up.
  assign timeout = ((state == ST_ENTER) || (state == ST_EXIT)) &&
                   (tmr == TMR_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr <= '0;
    end else if ((state_nxt != state) ||
                 !((state == ST_ENTER) || (state == ST_EXIT))) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    inc       = 1'b0;
    dec       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sens_in && !sens_out)      state_nxt = ST_CHECK;
        else if (!sens_in && sens_out) state_nxt = ST_EXIT;
        else if (sens_in && sens_out)  state_nxt = ST_CONFLICT;
      end
      ST_CHECK: begin
        // Metal wins even while the lane is waiting for a grant.
        if (metal)      state_nxt = ST_ALARM;
        else if (grant) state_nxt = ST_ENTER;
      end
      ST_ENTER: begin
        if (clear) begin
          state_nxt = ST_IDLE;
          inc       = 1'b1;
        end else if (timeout) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_EXIT: begin
        if (clear) begin
          state_nxt = ST_IDLE;
          dec       = 1'b1;
        end else if (timeout) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_CONFLICT: begin
        if (!sens_in && sens_out) state_nxt = ST_EXIT;
        else if (clear)           state_nxt = ST_IDLE;
      end
      ST_ALARM: begin
        // An ack while someone is still in the lane is deliberately ignored.
        if (alarm_ack && clear) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/turnstile_bank_ctrl.sv
// -----------------------------------------------------------------------------
// turnstile_bank_ctrl
//   Bank of LANES bidirectional turnstiles sharing one saturating occupancy
//   counter. Optional passage timeout per lane: define TURNSTILE_TIMEOUT_EN.
//   Ports:
//     clk, rst    : clock, asynchronous active-high reset
//     sens_in     : [LANES] entry-side sensors
//     sens_out    : [LANES] exit-side sensors
//     metal       : [LANES] metal detectors
//     alarm_ack   : guard acknowledge for all lanes
//     led_green   : [LANES] lane open (ENTER/EXIT)
//     led_red     : [LANES] lane in CONFLICT/ALARM
//     buzzer      : [LANES] lane in ALARM
//     dir         : [2*LANES] per lane {out,in}
//     occ_count   : [CNT_W] people inside, 0..CAPACITY
//     full        : occ_count + lanes in ENTER >= CAPACITY
//   All indicators decode registered state only (Moore).
// -----------------------------------------------------------------------------
module turnstile_bank_ctrl
  import turnstile_pkg::*;
#(
  parameter int LANES    = 2,
  parameter int CAPACITY = 15,
  parameter int CNT_W    = 4,
  parameter int TIMEOUT  = 50
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LANES-1:0]   sens_in,
  input  logic [LANES-1:0]   sens_out,
  input  logic [LANES-1:0]   metal,
  input  logic               alarm_ack,
  output logic [LANES-1:0]   led_green,
  output logic [LANES-1:0]   led_red,
  output logic [LANES-1:0]   buzzer,
  output logic [2*LANES-1:0] dir,
  output logic [CNT_W-1:0]   occ_count,
  output logic               full
);

  lane_state_e      st [LANES];
  lane_out_t        lo [LANES];
  logic [LANES-1:0] inc;
  logic [LANES-1:0] dec;
  logic [LANES-1:0] grant;
  logic [CNT_W-1:0] occ_nxt;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    turnstile_lane #(.TIMEOUT(TIMEOUT)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .sens_in   (sens_in[i]),
      .sens_out  (sens_out[i]),
      .metal     (metal[i]),
      .grant     (grant[i]),
      .alarm_ack (alarm_ack),
      .state     (st[i]),
      .inc       (inc[i]),
      .dec       (dec[i])
    );

    assign lo[i]             = lane_decode(st[i]);
    assign led_green[i]      = lo[i].green;
    assign led_red[i]        = lo[i].red;
    assign buzzer[i]         = lo[i].buzzer;
    assign dir[2*i+1 -: 2]   = lo[i].dir;
  end

  // Lanes already in ENTER count against capacity so a second grant can never
  // push the completed count past CAPACITY.
  always_comb begin
    int n_enter;
    n_enter = 0;
    for (int i = 0; i < LANES; i++) begin
      if (st[i] == ST_ENTER) n_enter = n_enter + 1;
    end
    full = (int'(occ_count) + n_enter) >= CAPACITY;
  end

  // Single grant per cycle, lowest index first, among CHECK lanes that are not
  // about to alarm on metal.
  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (!found && !full && (st[i] == ST_CHECK) && !metal[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  // Net occupancy change from all completions this cycle, clamped to range.
  always_comb begin
    int net;
    net = int'(occ_count);
    for (int i = 0; i < LANES; i++) begin
      if (inc[i]) net = net + 1;
      if (dec[i]) net = net - 1;
    end
    if (net < 0)        net = 0;
    if (net > CAPACITY) net = CAPACITY;
    occ_nxt = CNT_W'(net);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) occ_count <= '0;
    else     occ_count <= occ_nxt;
  end

endmodule
